stat_display: RTL and testbench
===============================

Name: stat_display

Overview:
Display stage directly downstream of the pipeline statistics counter block on the FPGA board. It takes the five 32-bit statistics counters (total cycles, conditional branches, unconditional jumps, correct conditional branches, load-use stalls) and selects one of them. It periodically snapshots the selected counter and converts it to decimal with a sequential double-dabble engine, or passes it through as hex. It then drives an 8-digit multiplexed active-low 7-segment display.

Parameters:
REFRESH_CYCLES, 1000000, clk cycles between automatic snapshots (min 40)
SCAN_DIV, 50000, clk cycles each digit stays enabled (min 1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset
sel  in  3  counter select: 0 total, 1 conditional, 2 unconditional, 3 conditional_success, 4 lu_times, 5-7 constant 0
hex_mode  in  1  1 = show 8 hex nibbles, 0 = decimal
total  in  32  statistics counter
conditional  in  32  statistics counter
unconditional  in  32  statistics counter
conditional_success  in  32  statistics counter
lu_times  in  32  statistics counter
an  out  8  digit enables, active-low, an[0] = rightmost digit
seg  out  8  segments, active-low, seg[6:0]=g..a, seg[7]=dp
busy  out  1  conversion in progress
ovf  out  1  latched decimal value >= 100000000

Behaviour:
- Reset: rst, synchronous, active-high. All state clears in the same edge:
  - an=8'hFF, seg=8'hFF, busy=0, ovf=0
  - display register=0, FSM=IDLE, refresh_cnt=0, scan_cnt=0, digit index=0, pending=0, sel_q=sel, hex_q=0
- Snapshot trigger, evaluated when FSM is IDLE:
  - refresh_cnt==0, or pending==1
  - refresh_cnt runs REFRESH_CYCLES-1 down to 0 and wraps, counting in every state
  - The first snapshot fires on the first edge after rst deasserts.
- Change detect:
  - When sel!=sel_q or hex_mode!=hex_q, register the new values.
  - If FSM is IDLE, trigger a snapshot next cycle. Otherwise set pending=1; pending clears on snapshot.
- FSM (busy=1 in LOAD/SHIFT/DONE):
  - IDLE -> LOAD on trigger.
  - LOAD: latch mux(sel_q) into a 32-bit shift register, clear the 40-bit BCD register, latch hex_q. Go to SHIFT in decimal mode, DONE in hex mode.
  - SHIFT: 32 iterations. Each iteration adds 3 to every BCD nibble >=5, then shifts {bcd,bin} left by 1. Iteration counter 0..31; at 31 go to DONE.
  - DONE: write the display register (decimal = BCD[31:0], hex = raw value), set ovf = |BCD[39:32] (0 in hex mode), go to IDLE.
- Latency from LOAD edge to display update: decimal 34 cycles, hex 2 cycles. The old display is held until DONE, so there is no flicker.
- Input counters may change during conversion; only the LOAD-edge value is used.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. On wrap, the digit index goes 0..7 and wraps to 0.
  - an = ~(1<<index); seg is registered, same cycle as an.
- Glyphs: 0-9, A-F (b, d lowercase); digit '0' = 7'b1000000 (active-low g..a), blank = 7'b1111111.
- Leading-zero blanking in decimal mode only: digits above the highest nonzero digit are blank. Digit 0 is always shown. Hex mode shows all 8 digits.
- Decimal point: seg[7]=0 only on digit 7 when ovf=1, otherwise 1.

Test Plan:
- Reset with SCAN_DIV=1, REFRESH_CYCLES=100, sel=0, total=1234 -> an=FF/seg=FF during rst. busy high 34 cycles after first snapshot. Digits 3..0 show 1,2,3,4 (digit 0 seg=0x99). Digits 7..4 seg=0xFF.
- sel=4, lu_times=32'hFFFFFFFF, decimal -> ovf=1. Display shows 94967295. Digit 7 seg[7]=0.
- hex_mode=1, sel=1, conditional=32'h00AB_0010 -> update 2 cycles after LOAD. Digits show 0,0,A,b,0,0,1,0 with no blanking; ovf=0.
- Change sel 0->2 mid-SHIFT -> current conversion completes with the old value. pending=1, then a new LOAD on the cycle after DONE/IDLE. Final display = unconditional.
- Change total every cycle during conversion -> displayed value equals total at the LOAD edge.
- Assert rst mid-SHIFT -> next edge: busy=0, display=0, an=FF. A new snapshot fires on the first edge after release.

Source files
------------

// File: rtl/stat_display.sv
// ---------------------------------------------------------------------------
// stat_display
//
// Display stage for the pipeline statistics counters. One of the five 32-bit
// counters is chosen with sel, snapshotted periodically (or right after the
// selection/mode changes), converted to decimal with a sequential
// double-dabble engine (or passed through as hex) and shown on an 8-digit
// multiplexed, active-low 7-segment display.
//
// Ports:
//   clk                 system clock, all logic on posedge
//   rst                 synchronous active-high reset
//   sel[2:0]            counter select (0 total .. 4 lu_times, 5-7 -> 0)
//   hex_mode            1 = 8 hex nibbles, 0 = decimal with zero blanking
//   total .. lu_times   32-bit statistics counters
//   an[7:0]             digit enables, active-low, an[0] = rightmost digit
//   seg[7:0]            segments, active-low, seg[6:0] = g..a, seg[7] = dp
//   busy                conversion in progress (LOAD/SHIFT/DONE)
//   ovf                 last decimal value did not fit in 8 digits
//
// States:
//   IDLE  | waiting for refresh tick or pending change
//   LOAD  | latch selected counter, clear BCD, latch display mode
//   SHIFT | 32 double-dabble iterations
//   DONE  | publish result to display register, set ovf
// ---------------------------------------------------------------------------
module stat_display #(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int SCAN_DIV       = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sel,
    input  logic        hex_mode,
    input  logic [31:0] total,
    input  logic [31:0] conditional,
    input  logic [31:0] unconditional,
    input  logic [31:0] conditional_success,
    input  logic [31:0] lu_times,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        busy,
    output logic        ovf
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SW = $clog2(SCAN_DIV + 1);

    localparam logic [RW-1:0] REFRESH_TOP = RW'(REFRESH_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_TOP    = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [RW-1:0]   refresh_cnt;
    logic [SW-1:0]   scan_cnt;
    logic [2:0]      digit_idx;
    logic            pending;
    logic [2:0]      sel_q;
    logic            hex_q;

    // Conversion datapath
    logic            conv_hex;
    logic [31:0]     bin;
    logic [39:0]     bcd;
    logic [4:0]      iter;

    // Published result; only changes in DONE so the display never flickers
    logic [31:0]     disp;
    logic            disp_hex;

    // Combinational helpers
    logic [31:0]     mux_val;
    logic [39:0]     bcd_adj;
    logic            changed;
    logic            trigger;
    logic [3:0]      cur_nib;
    logic            cur_blank;
    logic [7:0]      an_next;
    logic [7:0]      seg_next;

    // -----------------------------------------------------------------------
    // Segment glyphs, active-low g..a; b and d are lowercase
    // -----------------------------------------------------------------------
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // -----------------------------------------------------------------------
    // Counter select
    // -----------------------------------------------------------------------
    always_comb begin
        mux_val = 32'd0;
        case (sel_q)
            3'd0:    mux_val = total;
            3'd1:    mux_val = conditional;
            3'd2:    mux_val = unconditional;
            3'd3:    mux_val = conditional_success;
            3'd4:    mux_val = lu_times;
            default: mux_val = 32'd0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    // -----------------------------------------------------------------------
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Snapshot control
    // -----------------------------------------------------------------------
    assign changed = (sel != sel_q) || (hex_mode != hex_q);
    assign trigger = (state == IDLE) && ((refresh_cnt == '0) || pending);

    // -----------------------------------------------------------------------
    // Scan output for the digit currently indexed. A digit is blank in
    // decimal mode when it and everything above it is zero; digit 0 always
    // shows so a zero value reads as "0".
    // -----------------------------------------------------------------------
    always_comb begin
        cur_nib   = disp[{digit_idx, 2'b00} +: 4];
        cur_blank = !disp_hex && (digit_idx != 3'd0) &&
                    ((disp >> {digit_idx, 2'b00}) == 32'd0);
        an_next   = ~(8'd1 << digit_idx);
        seg_next  = {~(ovf && (digit_idx == 3'd7)),
                     cur_blank ? 7'b1111111 : glyph(cur_nib)};
    end

    // -----------------------------------------------------------------------
    // Sequential logic
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            refresh_cnt <= '0;
            scan_cnt    <= '0;
            digit_idx   <= 3'd0;
            pending     <= 1'b0;
            sel_q       <= sel;
            hex_q       <= 1'b0;
            conv_hex    <= 1'b0;
            bin         <= 32'd0;
            bcd         <= 40'd0;
            iter        <= 5'd0;
            disp        <= 32'd0;
            disp_hex    <= 1'b0;
            an          <= 8'hFF;
            seg         <= 8'hFF;
            busy        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            // Free-running refresh timer, counts in every state
            if (refresh_cnt == '0) begin
                refresh_cnt <= REFRESH_TOP;
            end else begin
                refresh_cnt <= refresh_cnt - 1'b1;
            end

            // Digit multiplexing
            if (scan_cnt == SCAN_TOP) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt  <= scan_cnt + 1'b1;
            end
            an  <= an_next;
            seg <= seg_next;

            // Selection/mode change. When a snapshot starts on this same edge
            // LOAD reads the freshly registered sel_q, so nothing is pending.
            if (changed) begin
                sel_q <= sel;
                hex_q <= hex_mode;
            end
            if (trigger) begin
                pending <= 1'b0;
            end else if (changed) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end

                LOAD: begin
                    bin      <= mux_val;
                    bcd      <= 40'd0;
                    conv_hex <= hex_q;
                    iter     <= 5'd0;
                    state    <= hex_q ? DONE : SHIFT;
                end

                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[38:0], bin, 1'b0};
                    iter       <= iter + 5'd1;
                    if (iter == 5'd31) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    disp     <= conv_hex ? bin : bcd[31:0];
                    disp_hex <= conv_hex;
                    ovf      <= conv_hex ? 1'b0 : |bcd[39:32];
                    state    <= IDLE;
                    busy     <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stat_display.sv
module tb_stat_display;

    logic        clk;
    logic        rst;
    logic [2:0]  sel;
    logic        hex_mode;
    logic [31:0] total;
    logic [31:0] conditional;
    logic [31:0] unconditional;
    logic [31:0] conditional_success;
    logic [31:0] lu_times;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        busy;
    logic        ovf;

    stat_display #(.REFRESH_CYCLES(100), .SCAN_DIV(1)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .sel                 (sel),
        .hex_mode            (hex_mode),
        .total               (total),
        .conditional         (conditional),
        .unconditional       (unconditional),
        .conditional_success (conditional_success),
        .lu_times            (lu_times),
        .an                  (an),
        .seg                 (seg),
        .busy                (busy),
        .ovf                 (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] disp;
        logic        hex;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [2:0]  sel;
        logic        hex;
        logic [31:0] val;
        logic [31:0] exp_disp;
        logic        exp_ovf;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] gl(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] d, input logic hx,
                                           input logic ov, input int i);
        logic blank;
        blank = !hx && (i != 0) && ((d >> (4 * i)) == 32'd0);
        return {~(ov && (i == 7)), blank ? 7'h7F : gl(d[4*i +: 4])};
    endfunction

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] x;
        r = 32'd0;
        x = v % 32'd100000000;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 32'd10);
            x = x / 32'd10;
        end
        return r;
    endfunction

    // Sample 8 consecutive scan slots and compare every digit
    task automatic check_display(input logic [31:0] d, input logic hx,
                                 input logic ov, input string nm);
        int idx;
        step();
        chk({nm, "_ovf"}, ovf, ov);
        for (int k = 0; k < 8; k++) begin
            step();
            idx = -1;
            for (int j = 0; j < 8; j++) if (an == ~(8'd1 << j)) idx = j;
            if (idx < 0) begin
                n_total++;
                $display("FAIL %s_an: got %0h expected one-hot-low", nm, an);
            end else begin
                chk($sformatf("%s_dig%0d", nm, idx), seg, exp_seg(d, hx, ov, idx));
            end
        end
    endtask

    task automatic count_busy(output int hi);
        hi = 0;
        while (busy && hi < 200) begin
            hi++;
            step();
        end
    endtask

    task automatic wait_level(input logic lvl, input int budget, input string nm);
        int k;
        k = 0;
        while (busy !== lvl && k < budget) begin
            step();
            k++;
        end
        if (busy !== lvl) begin
            n_total++;
            $display("FAIL %s_timeout: busy got %0b expected %0b", nm, busy, lvl);
        end
    endtask

    // Finish any conversion in flight, then measure the next complete one
    task automatic wait_conv(output int hi, input string nm);
        wait_level(1'b0, 200, nm);
        wait_level(1'b1, 300, nm);
        count_busy(hi);
    endtask

    task automatic apply(input vec_t v);
        total               = $urandom;
        conditional         = $urandom;
        unconditional       = $urandom;
        conditional_success = $urandom;
        lu_times            = $urandom;
        sel      = v.sel;
        hex_mode = v.hex;
        case (v.sel)
            3'd0: total               = v.val;
            3'd1: conditional         = v.val;
            3'd2: unconditional       = v.val;
            3'd3: conditional_success = v.val;
            3'd4: lu_times            = v.val;
            default: ;
        endcase
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hi;
        exp_t e;
        logic [31:0] cnt;
        logic [31:0] cap;
        logic        seen;
        int          k;

        vecs[0] = '{3'd0, 1'b0, 32'd1234,       32'h00001234, 1'b0, 34};
        vecs[1] = '{3'd4, 1'b0, 32'hFFFFFFFF,   32'h94967295, 1'b1, 34};
        vecs[2] = '{3'd1, 1'b1, 32'h00AB0010,   32'h00AB0010, 1'b0, 2};
        vecs[3] = '{3'd2, 1'b0, 32'd0,          32'h00000000, 1'b0, 34};
        vecs[4] = '{3'd3, 1'b0, 32'd99999999,   32'h99999999, 1'b0, 34};
        vecs[5] = '{3'd3, 1'b0, 32'd100000000,  32'h00000000, 1'b1, 34};
        vecs[6] = '{3'd5, 1'b0, 32'd777,        32'h00000000, 1'b0, 34};
        vecs[7] = '{3'd0, 1'b1, 32'hDEADBEEF,   32'hDEADBEEF, 1'b0, 2};
        vecs[8] = '{3'd2, 1'b0, 32'd1000,       32'h00001000, 1'b0, 34};
        vecs[9] = '{3'd4, 1'b1, 32'd0,          32'h00000000, 1'b0, 2};

        // Reset behaviour and first snapshot
        rst = 1'b1;
        sel = 3'd0;
        hex_mode = 1'b0;
        total = 32'd1234;
        conditional = 32'd0;
        unconditional = 32'd0;
        conditional_success = 32'd0;
        lu_times = 32'd0;
        repeat (3) step();
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        step();
        chk("first_snapshot_busy", busy, 1'b1);
        count_busy(hi);
        chk("first_busy_len", hi, 34);
        check_display(32'h00001234, 1'b0, 1'b0, "first");

        // Table-driven vectors through a scoreboard
        foreach (vecs[i]) begin
            apply(vecs[i]);
            sb.push_back('{vecs[i].exp_disp, vecs[i].hex, vecs[i].exp_ovf});
            wait_conv(hi, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_busy_len", i), hi, vecs[i].exp_busy);
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL vec%0d_sb: got empty queue expected entry", i);
            end else begin
                e = sb.pop_front();
                check_display(e.disp, e.hex, e.ovf, $sformatf("vec%0d", i));
            end
        end

        // Selection change mid-SHIFT: old value completes, then pending reload
        sel = 3'd0;
        hex_mode = 1'b0;
        total = 32'd87654321;
        unconditional = 32'd13579;
        wait_conv(hi, "midsel_setup");
        wait_level(1'b1, 300, "midsel_start");
        repeat (10) step();
        sel = 3'd2;
        wait_level(1'b0, 200, "midsel_done");
        step();
        chk("midsel_reload", busy, 1'b1);
        check_display(32'h87654321, 1'b0, 1'b0, "midsel_old");
        wait_level(1'b0, 200, "midsel_new");
        check_display(32'h00013579, 1'b0, 1'b0, "midsel_new");

        // Source counter changing every cycle: LOAD-edge value is used
        sel = 3'd0;
        wait_conv(hi, "moving_setup");
        cnt = 32'd10000000;
        cap = 32'd0;
        seen = 1'b0;
        k = 0;
        while (k < 400 && !(seen && !busy)) begin
            step();
            total = cnt;
            cnt++;
            if (!seen && busy) begin
                cap = total;
                seen = 1'b1;
            end
            k++;
        end
        if (!(seen && !busy)) begin
            n_total++;
            $display("FAIL moving_timeout: busy got %0b seen %0b", busy, seen);
        end
        check_display(to_bcd(cap), 1'b0, 1'b0, "moving");

        // Reset in the middle of SHIFT
        sel = 3'd4;
        lu_times = 32'hFFFFFFFF;
        wait_conv(hi, "midrst_setup");
        wait_level(1'b1, 300, "midrst_start");
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_an", an, 8'hFF);
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_ovf", ovf, 1'b0);
        rst = 1'b0;
        step();
        chk("midrst_restart", busy, 1'b1);
        check_display(32'h00000000, 1'b0, 1'b0, "midrst_cleared");
        wait_level(1'b0, 200, "midrst_end");
        check_display(32'h94967295, 1'b0, 1'b1, "midrst_final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
